// File: rtl/buzz_pkg.sv
// buzz_pkg: shared types and defaults for the buzzer alarm scheduler.
// Holds the scheduler state enumeration, the default timing constants
// (tone half-period, beep length, inter-beep gap, post-burst guard time),
// the default beep counts per requester, and small helper functions.
package buzz_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int unsigned DEF_TONE_DIV = 32'd16384;
    localparam int unsigned DEF_ON_CYC   = 32'd16777216;
    localparam int unsigned DEF_OFF_CYC  = 32'd16777216;
    localparam int unsigned DEF_GAP_CYC  = 32'd33554432;

    localparam int unsigned DEF_BEEPS0 = 32'd1;
    localparam int unsigned DEF_BEEPS1 = 32'd2;
    localparam int unsigned DEF_BEEPS2 = 32'd3;

    // Fixed priority: requester 2 beats 1 beats 0; result is one-hot or zero.
    function automatic logic [2:0] pick_onehot(input logic [2:0] pend);
        logic [2:0] win;
        if (pend[2]) begin
            win = 3'b100;
        end else if (pend[1]) begin
            win = 3'b010;
        end else if (pend[0]) begin
            win = 3'b001;
        end else begin
            win = 3'b000;
        end
        return win;
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/buzz_tone.sv
// buzz_tone: square-wave tone divider for the buzzer.
// Ports:
//   clk   in  1  clock, rising edge
//   rst_n in  1  asynchronous active-low reset
//   en    in  1  tone enable; while low the phase is held at its start
//   tone  out 1  square wave, 0 on the first enabled cycle, toggles every
//                TONE_DIV enabled cycles
// Holding the divider cleared while en is low means every rise of en
// restarts the phase from 0.
module buzz_tone #(
    parameter int unsigned TONE_DIV = 32'd16384
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tone
);

    localparam int unsigned TW = (TONE_DIV > 32'd1) ? $clog2(TONE_DIV) : 32'd1;

    logic [TW-1:0] div_r;
    logic          tone_r;

    // Half-period divider and tone flop; cleared whenever disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r  <= '0;
            tone_r <= 1'b0;
        end else if (!en) begin
            div_r  <= '0;
            tone_r <= 1'b0;
        end else if (div_r == TW'(TONE_DIV - 32'd1)) begin
            div_r  <= '0;
            tone_r <= ~tone_r;
        end else begin
            div_r  <= div_r + TW'(1);
            tone_r <= tone_r;
        end
    end

    assign tone = tone_r;

endmodule

// File: rtl/buzz_sched.sv
// buzz_sched: three-requester alarm buzzer scheduler.
// A rising edge on req[i] latches a pending request; the highest pending
// index is served with a burst of BEEPSi beeps (ON_CYC tone, OFF_CYC silence
// between beeps) followed by a GAP_CYC silent guard time.
// Ports:
//   clk   in  1  clock, rising edge
//   rst_n in  1  asynchronous active-low reset
//   req   in  3  alarm requests (rising-edge sensitive)
//   mute  in  1  silences immediately, aborts burst, clears pending
//   beep  out 1  buzzer drive, active-low (1 = silent)
//   grant out 3  one-hot requester being served, 0 when idle
//   busy  out 1  state is not IDLE
//   done  out 1  one-cycle pulse on the last GAP cycle
module buzz_sched
    import buzz_pkg::*;
#(
    parameter int unsigned TONE_DIV = DEF_TONE_DIV,
    parameter int unsigned ON_CYC   = DEF_ON_CYC,
    parameter int unsigned OFF_CYC  = DEF_OFF_CYC,
    parameter int unsigned GAP_CYC  = DEF_GAP_CYC,
    parameter int unsigned BEEPS0   = DEF_BEEPS0,
    parameter int unsigned BEEPS1   = DEF_BEEPS1,
    parameter int unsigned BEEPS2   = DEF_BEEPS2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       mute,
    output logic       beep,
    output logic [2:0] grant,
    output logic       busy,
    output logic       done
);

    localparam int unsigned MAX_CYC = max3(ON_CYC, OFF_CYC, GAP_CYC);
    localparam int unsigned CW      = (MAX_CYC > 32'd1) ? $clog2(MAX_CYC) : 32'd1;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [3:0]    beeps_r, beeps_s;
    logic [2:0]    grant_r, grant_s;
    logic [2:0]    pend_r, pend_s;
    logic [2:0]    req_d_r;
    logic          armed_r;
    logic          busy_r;
    logic          done_r, done_s;
    logic [2:0]    rise_s;
    logic [2:0]    win_s;
    logic          start_s;
    logic          tone_s;
    logic          beep_s;

    // Next-state, counter, grant and pending-request logic.
    always_comb begin
        // armed_r masks the first cycle after reset so a held req is not an edge
        rise_s  = req & ~req_d_r & {3{armed_r}};
        win_s   = pick_onehot(pend_r);
        start_s = 1'b0;
        state_s = state_r;
        cnt_s   = cnt_r;
        beeps_s = beeps_r;
        grant_s = grant_r;
        pend_s  = pend_r | rise_s;
        done_s  = 1'b0;

        if (mute) begin
            state_s = ST_IDLE;
            cnt_s   = '0;
            beeps_s = 4'd0;
            grant_s = 3'b000;
            pend_s  = 3'b000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pend_r != 3'b000) begin
                        start_s = 1'b1;
                    end else begin
                        start_s = 1'b0;
                    end
                end
                ST_ON: begin
                    if (cnt_r == '0) begin
                        beeps_s = beeps_r - 4'd1;
                        if (beeps_r > 4'd1) begin
                            state_s = ST_OFF;
                            cnt_s   = CW'(OFF_CYC - 32'd1);
                        end else begin
                            state_s = ST_GAP;
                            cnt_s   = CW'(GAP_CYC - 32'd1);
                        end
                    end else begin
                        cnt_s = cnt_r - CW'(1);
                    end
                end
                ST_OFF: begin
                    if (cnt_r == '0) begin
                        state_s = ST_ON;
                        cnt_s   = CW'(ON_CYC - 32'd1);
                    end else begin
                        cnt_s = cnt_r - CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_r == '0) begin
                        // A request already waiting is handed the buzzer
                        // straight away, on the cycle right after done.
                        if (pend_r != 3'b000) begin
                            start_s = 1'b1;
                        end else begin
                            state_s = ST_IDLE;
                            grant_s = 3'b000;
                        end
                    end else begin
                        cnt_s = cnt_r - CW'(1);
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                    grant_s = 3'b000;
                end
            endcase

            if (start_s) begin
                state_s = ST_ON;
                cnt_s   = CW'(ON_CYC - 32'd1);
                grant_s = win_s;
                pend_s  = (pend_r & ~win_s) | rise_s;
                if (win_s[2]) begin
                    beeps_s = 4'(BEEPS2);
                end else if (win_s[1]) begin
                    beeps_s = 4'(BEEPS1);
                end else begin
                    beeps_s = 4'(BEEPS0);
                end
            end else begin
                pend_s = pend_s;
            end

            // Registered so done is high exactly during the last GAP cycle.
            done_s = (state_s == ST_GAP) && (cnt_s == '0);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            beeps_r <= 4'd0;
            grant_r <= 3'b000;
            pend_r  <= 3'b000;
            req_d_r <= 3'b000;
            armed_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            beeps_r <= beeps_s;
            grant_r <= grant_s;
            pend_r  <= pend_s;
            req_d_r <= req;
            armed_r <= 1'b1;
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= done_s;
        end
    end

    buzz_tone #(
        .TONE_DIV (TONE_DIV)
    ) u_tone (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_r == ST_ON),
        .tone  (tone_s)
    );

    // Buzzer drive: mute silences within the same cycle.
    always_comb begin
        beep_s = 1'b1;
        if (mute) begin
            beep_s = 1'b1;
        end else if (state_r == ST_ON) begin
            beep_s = tone_s;
        end else begin
            beep_s = 1'b1;
        end
    end

    assign beep  = beep_s;
    assign grant = grant_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_buzz_sched.sv
// tb_buzz_sched: self-checking bench for buzz_sched with short timing
// (TONE_DIV=2, ON_CYC=8, OFF_CYC=4, GAP_CYC=6, beeps 1/2/3).
// Each scenario pushes the expected per-cycle {busy, grant, beep, done}
// onto a queue as its stimulus is planned; every cycle pops one entry and
// compares it with the DUT outputs sampled on the falling edge.
module tb_buzz_sched;

    localparam int TD  = 2;
    localparam int ONC = 8;
    localparam int OFC = 4;
    localparam int GPC = 6;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req   = 3'b000;
    logic       mute  = 1'b0;
    logic       beep;
    logic [2:0] grant;
    logic       busy;
    logic       done;

    int n_tests  = 0;
    int n_fail   = 0;
    int cyc_no   = 0;
    int busy_cnt = 0;

    logic [5:0] exp_q[$];

    buzz_sched #(
        .TONE_DIV (32'd2),
        .ON_CYC   (32'd8),
        .OFF_CYC  (32'd4),
        .GAP_CYC  (32'd6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .mute  (mute),
        .beep  (beep),
        .grant (grant),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back({1'b0, 3'b000, 1'b1, 1'b0});
    endtask

    // Expected trace of one complete burst for requester i with nb beeps.
    task automatic push_burst(input int i, input int nb);
        logic [2:0] g;
        logic       bp;
        g = 3'(3'b001 << i);
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < ONC; k++) begin
                bp = 1'((k / TD) % 2);
                exp_q.push_back({1'b1, g, bp, 1'b0});
            end
            if (b < nb - 1) begin
                for (int k = 0; k < OFC; k++) exp_q.push_back({1'b1, g, 1'b1, 1'b0});
            end
        end
        for (int k = 0; k < GPC; k++) exp_q.push_back({1'b1, g, 1'b1, (k == GPC - 1)});
    endtask

    task automatic drop_tail(input int n);
        for (int k = 0; k < n; k++) void'(exp_q.pop_back());
    endtask

    // One clock cycle: drive after the rising edge, check on the falling edge.
    task automatic cyc(input string tag, input logic [2:0] r, input logic m, input logic rn);
        @(posedge clk);
        #1;
        req   = r;
        mute  = m;
        rst_n = rn;
        @(negedge clk);
        if (busy) busy_cnt++;
        if (exp_q.size() == 0) begin
            chk($sformatf("%s_qsize@%0d", tag, cyc_no), 32'(exp_q.size()), 32'd1);
        end else begin
            chk($sformatf("%s@%0d", tag, cyc_no), 32'({busy, grant, beep, done}),
                32'(exp_q.pop_front()));
        end
        cyc_no++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values, then release.
        push_idle(5);
        for (int t = 0; t < 3; t++) cyc("reset", 3'b000, 1'b0, 1'b0);
        for (int t = 0; t < 2; t++) cyc("release", 3'b000, 1'b0, 1'b1);

        // Single-cycle req[0]: one beep, gap, done, back to idle.
        push_idle(2); push_burst(0, 1); push_idle(3);
        for (int t = 0; t < 19; t++) cyc("req0", (t == 0) ? 3'b001 : 3'b000, 1'b0, 1'b1);
        chk("req0_drain", 32'(exp_q.size()), 32'd0);

        // req[2]: three beeps, 38 busy cycles.
        busy_cnt = 0;
        push_idle(2); push_burst(2, 3); push_idle(2);
        for (int t = 0; t < 42; t++) cyc("req2", (t == 0) ? 3'b100 : 3'b000, 1'b0, 1'b1);
        chk("req2_busy_len", 32'(busy_cnt), 32'd38);

        // Simultaneous req 011: requester 1 first, requester 0 right after done.
        push_idle(2); push_burst(1, 2); push_burst(0, 1); push_idle(2);
        for (int t = 0; t < 44; t++) cyc("req011", (t == 0) ? 3'b011 : 3'b000, 1'b0, 1'b1);

        // req[2] during req[0]'s ON: no preemption, served after done.
        push_idle(2); push_burst(0, 1); push_burst(2, 3); push_idle(2);
        for (int t = 0; t < 56; t++)
            cyc("nopreempt", (t == 0) ? 3'b001 : ((t == 4) ? 3'b100 : 3'b000), 1'b0, 1'b1);

        // Mute in the second ON window; req edges under mute are dropped.
        push_idle(2); push_burst(2, 3); drop_tail(25);
        exp_q.push_back({1'b1, 3'b100, 1'b1, 1'b0});
        push_idle(16);
        for (int t = 0; t < 32; t++) begin
            logic [2:0] r;
            logic       m;
            r = 3'b000;
            m = (t >= 15 && t <= 18) || (t == 26);
            if (t == 0)  r = 3'b100;
            if (t == 17) r = 3'b010;
            if (t == 26) r = 3'b001;
            cyc("mute", r, m, 1'b1);
        end

        // Reset mid-OFF with req[1] held through release.
        push_idle(2); push_burst(2, 3); drop_tail(29);
        push_idle(14); push_burst(1, 2); push_idle(2);
        for (int t = 0; t < 53; t++) begin
            logic [2:0] r;
            logic       rn;
            r  = 3'b000;
            rn = !(t == 11 || t == 12);
            if (t == 0) r = 3'b100;
            if ((t >= 11 && t <= 20) || t == 23) r = 3'b010;
            cyc("rst_mid", r, 1'b0, rn);
        end
        chk("final_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/buzz_sched.md
BUZZ_SCHED -- requirements
Module: buzz_sched

Interface
REQ-001 Parameter TONE_DIV, default 16384: tone half-period in clk cycles.
REQ-002 Parameter ON_CYC, default 16777216: length of one beep in clk cycles.
REQ-003 Parameter OFF_CYC, default 16777216: silent gap between beeps in a burst.
REQ-004 Parameter GAP_CYC, default 33554432: silent guard time after each burst.
REQ-005 Parameters BEEPS0/BEEPS1/BEEPS2, defaults 1/2/3: beeps per burst for each requester; legal range is 1..15.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 req  in  3  alarm requests, one bit per requester; a pulse of one or more cycles is a request.
REQ-009 mute  in  1  silences the buzzer, aborts the burst and clears all pending requests.
REQ-010 beep  out  1  buzzer drive, active-low: 1 = silent.
REQ-011 grant  out  3  one-hot requester being served; 0 when idle.
REQ-012 busy  out  1  high whenever the state is not IDLE.
REQ-013 done  out  1  one-cycle pulse on the last cycle of GAP.

Function
REQ-014 A rising edge of req[i] sets pend[i]; pend[i] stays set until requester i is granted.
- A held-high req does not re-arm.
- A new rising edge after the grant sets pend[i] again.
REQ-015 State machine states: IDLE, ON, OFF, GAP.
REQ-016 IDLE -> ON occurs on the cycle after any pend bit is high.
- The highest-index pending requester wins (fixed priority, 2 highest).
- Its pend bit clears.
- grant is registered and held until GAP ends.
REQ-017 ON lasts exactly ON_CYC cycles.
- If more beeps remain, ON -> OFF; otherwise ON -> GAP.
REQ-018 OFF lasts exactly OFF_CYC cycles, then returns to ON.
REQ-019 GAP lasts exactly GAP_CYC cycles.
- Then GAP -> IDLE, with grant = 0 and done = 1 for that last cycle.
- A pending request is granted on the next cycle.
REQ-020 No preemption: a higher-priority request arriving mid-burst stays pending until the burst completes.
REQ-021 In ON, beep is a square wave that toggles every TONE_DIV cycles, starting at 0 on the first ON cycle.
REQ-022 In every other state, beep = 1.
REQ-023 The beep counter is 4 bits and loads BEEPSi at grant; it decrements at each ON exit.
REQ-024 The phase counters are sized with clog2 of the largest of ON_CYC, OFF_CYC and GAP_CYC.
- Counters reload on every state entry and never wrap.
REQ-025 mute = 1 forces beep = 1 combinationally.
- On the next edge: state -> IDLE, grant = 0 and pend = 0.
- done does not pulse.
- Rising edges on req while mute is high are ignored.
REQ-026 If mute and a req edge occur in the same cycle, mute wins and the request is dropped.
REQ-027 If several req edges arrive in the same cycle while idle, the highest index is granted; the others stay pending and are served in descending order.

Reset
REQ-028 While rst_n = 0, asynchronously:
- state = IDLE, beep = 1, grant = 0, busy = 0, done = 0.
- pend = 0, all counters = 0, req edge-history register = 0.
REQ-029 Reset asserted mid-burst silences the buzzer immediately; nothing is resumed after release.
REQ-030 A req held high through reset release is not a rising edge.

Structure
REQ-031 Package buzz_pkg holds:
- the state enumeration;
- the default timing constants (TONE_DIV, ON_CYC, OFF_CYC, GAP_CYC);
- the default beep counts.
REQ-032 The tone divider is the one sub-module, buzz_tone.
- Ports: clk, rst_n, en, tone.
- It restarts its phase when en rises.
REQ-033 All outputs except beep are driven directly from flops.

Verification
Bench parameters for all scenarios: TONE_DIV=2, ON_CYC=8, OFF_CYC=4, GAP_CYC=6.
REQ-034 Pulse req[0] for 1 cycle:
- grant = 001 from the second cycle on;
- exactly 1 beep burst with beep toggling every 2 cycles for 8 cycles;
- 6-cycle gap, then done pulses once and busy falls.
REQ-035 Pulse req[2]:
- 3 ON windows of 8 cycles separated by OFF windows of 4 cycles;
- total busy time = 3*8 + 2*4 + 6 = 38 cycles.
REQ-036 Assert req = 011 in the same cycle:
- grant = 010 (2 beeps) first;
- then grant = 001 on the cycle after done;
- no lost request.
REQ-037 During req[0]'s ON phase, pulse req[2]:
- burst 0 completes undisturbed;
- grant = 100 on the cycle after done.
REQ-038 Assert mute in the second ON window of a req[2] burst:
- beep = 1 in the same cycle;
- IDLE and grant = 0 on the next edge;
- no done pulse;
- a req[1] pulse while mute is high produces no burst.
REQ-039 Assert rst_n = 0 mid-OFF, holding req[1] high through release:
- outputs go to reset values immediately;
- no burst starts until req[1] falls and rises again.
